// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants and types for the shared shifter scheduler
package shift_pkg;

   localparam int SH_LATENCY = 7;
   localparam int DATA_W     = 32;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_ROL = 2'b10,
      OP_ROR = 2'b11
   } sh_op_e;

   // One tag rides alongside each shifter stage; only valid tags are captured.
   typedef struct packed {
      logic valid;
      logic id;
   } sh_tag_t;

endpackage

// File: rtl/shift_res_fifo.sv
// rtl/shift_res_fifo.sv - synchronous result FIFO with occupancy count
module shift_res_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 33,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // A pop on an empty FIFO is dropped; a push when full is only taken alongside a pop.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

   // Pointer wrap and occupancy bookkeeping.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/shift_unit_sched.sv
// rtl/shift_unit_sched.sv - round-robin scheduler sharing one pipelined shifter between two requesters
module shift_unit_sched
   import shift_pkg::*;
#(
   parameter int SH_LAT     = SH_LATENCY,
   parameter int FIFO_DEPTH = 8,
   parameter int ID_W       = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DATA_W-1:0] r0_a,
   input  logic [1:0]        r0_op,
   input  logic [4:0]        r0_bits,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r1_a,
   input  logic [1:0]        r1_op,
   input  logic [4:0]        r1_bits,
   output logic [DATA_W-1:0] sh_a,
   output logic [1:0]        sh_op,
   output logic [4:0]        sh_bits,
   input  logic [DATA_W-1:0] sh_out,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [ID_W-1:0]   resp_id,
   output logic [DATA_W-1:0] resp_data,
   output logic              busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   sh_tag_t            tag_q [SH_LAT];
   logic [CNT_W-1:0]   inflight_q, inflight_d;
   logic               mode_q, mode_d;
   logic               rr_q, rr_d;

   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_empty;
   logic [DATA_W:0]    fifo_head;

   logic [OCC_W-1:0]   occupancy;
   logic               pipe_empty, credit_ok;
   logic               mode_ok0, mode_ok1;
   logic               elig0, elig1;
   logic               mode_blk0, mode_blk1;
   logic               gnt0, gnt1, issue, gnt_id;
   logic [1:0]         issue_op;
   logic               capture;

   // A slot is reserved for every op in the pipe, so a capture always finds room.
   assign pipe_empty = (inflight_q == '0);
   assign occupancy  = OCC_W'(inflight_q) + OCC_W'(fifo_count);
   assign credit_ok  = (occupancy < OCC_W'(FIFO_DEPTH));

   // The shifter reads op[1] live in every stage, so only same-direction ops may share the pipe.
   assign mode_ok0  = pipe_empty || (r0_op[1] == mode_q);
   assign mode_ok1  = pipe_empty || (r1_op[1] == mode_q);
   assign elig0     = r0_valid && mode_ok0 && credit_ok;
   assign elig1     = r1_valid && mode_ok1 && credit_ok;
   assign mode_blk0 = r0_valid && credit_ok && !mode_ok0;
   assign mode_blk1 = r1_valid && credit_ok && !mode_ok1;

   // Round-robin grant; a priority requester waiting on a mode change freezes issue so the pipe drains.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (!rr_q) begin
            if (elig0)           gnt0 = 1'b1;
            else if (!mode_blk0) gnt1 = elig1;
         end else begin
            if (elig1)           gnt1 = 1'b1;
            else if (!mode_blk1) gnt0 = elig0;
         end
      end
   end

   assign issue    = gnt0 | gnt1;
   assign gnt_id   = gnt1;
   assign r0_ready = gnt0;
   assign r1_ready = gnt1;
   assign issue_op = gnt1 ? r1_op : r0_op;

   // Idle cycles keep op[1] at the current mode so in-flight ops are not disturbed.
   assign sh_a    = gnt1 ? r1_a : r0_a;
   assign sh_bits = gnt1 ? r1_bits : r0_bits;
   assign sh_op   = issue ? issue_op : {mode_q, 1'b0};

   assign capture = tag_q[SH_LAT-1].valid;

   // In-flight count, mode latch and round-robin pointer next state.
   always_comb begin
      inflight_d = inflight_q;
      case ({issue, capture})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
      mode_d = (issue && pipe_empty) ? issue_op[1] : mode_q;
      rr_d   = issue ? ~gnt_id : rr_q;
   end

   // Scheduler state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= '0;
         mode_q     <= 1'b0;
         rr_q       <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         mode_q     <= mode_d;
         rr_q       <= rr_d;
      end
   end

   // Tag shift register tracking which shifter stages hold a live op; reset orphans stale contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SH_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         tag_q[0] <= '{valid: issue, id: gnt_id};
         for (int k = 1; k < SH_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   shift_res_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W + 1)
   ) u_res_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (capture),
      .push_data_i ({tag_q[SH_LAT-1].id, sh_out}),
      .pop_i       (resp_ready),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign resp_valid = !fifo_empty;
   assign resp_id    = ID_W'(fifo_head[DATA_W]);
   assign resp_data  = fifo_head[DATA_W-1:0];
   assign busy       = !pipe_empty || !fifo_empty;

endmodule

// File: tb/tb_shift_unit_sched.sv
// tb/tb_shift_unit_sched.sv - self-checking bench for shift_unit_sched with a behavioural shifter
module tb_shift_unit_sched;

   localparam int SH_LAT     = 7;
   localparam int FIFO_DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r0_ready, r1_valid, r1_ready;
   logic [31:0] r0_a, r1_a;
   logic [1:0]  r0_op, r1_op;
   logic [4:0]  r0_bits, r1_bits;
   logic [31:0] sh_a, sh_out;
   logic [1:0]  sh_op;
   logic [4:0]  sh_bits;
   logic        resp_valid, resp_ready, busy;
   logic [0:0]  resp_id;
   logic [31:0] resp_data;

   int n_cmp, n_fail, cyc;

   // reference model state
   int          pend_t[$];
   logic [32:0] pend_e[$];
   logic [32:0] fq[$];
   bit          m_mode, m_rr;
   int          m_inf;
   bit          v[2], eg[2];
   logic [31:0] av[2];
   logic [1:0]  opv[2];
   logic [4:0]  bv[2];
   bit          exp_rv, exp_busy;
   logic [32:0] exp_head;

   // shifter pipeline registers (no reset)
   logic [31:0] p_a [SH_LAT];
   logic        p_op0 [SH_LAT];
   logic [4:0]  p_bits [SH_LAT];

   always #5 clk = ~clk;

   shift_unit_sched dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_op(r0_op), .r0_bits(r0_bits),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_op(r1_op), .r1_bits(r1_bits),
      .sh_a(sh_a), .sh_op(sh_op), .sh_bits(sh_bits), .sh_out(sh_out),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .busy(busy)
   );

   function automatic logic [31:0] shf(input logic [31:0] a, input logic [1:0] op, input logic [4:0] b);
      logic [63:0] w;
      w = {a, a};
      case (op)
         2'b00:   return a << b;
         2'b01:   return a >> b;
         2'b10:   begin w = w << b; return w[63:32]; end
         default: begin w = w >> b; return w[31:0]; end
      endcase
   endfunction

   // Behavioural shifter: 7 clocks of latency, op[1] taken live at the output.
   always @(posedge clk) begin
      p_a[0] <= sh_a; p_op0[0] <= sh_op[0]; p_bits[0] <= sh_bits;
      for (int k = 1; k < SH_LAT; k++) begin
         p_a[k] <= p_a[k-1]; p_op0[k] <= p_op0[k-1]; p_bits[k] <= p_bits[k-1];
      end
   end
   assign sh_out = shf(p_a[SH_LAT-1], {sh_op[1], p_op0[SH_LAT-1]}, p_bits[SH_LAT-1]);

   task automatic set_req(input int n, input logic vld, input logic [31:0] a, input logic [1:0] op, input logic [4:0] b);
      if (n == 0) begin r0_valid = vld; r0_a = a; r0_op = op; r0_bits = b; end
      else        begin r1_valid = vld; r1_a = a; r1_op = op; r1_bits = b; end
   endtask

   // Wait to the falling edge and predict this cycle's outputs from the model.
   task automatic settle();
      int  inf, fc, p;
      bit  credit;
      bit  ok[2], el[2];
      @(negedge clk);
      v[0] = r0_valid; av[0] = r0_a; opv[0] = r0_op; bv[0] = r0_bits;
      v[1] = r1_valid; av[1] = r1_a; opv[1] = r1_op; bv[1] = r1_bits;
      inf = pend_t.size(); fc = fq.size(); m_inf = inf;
      credit = (inf + fc) < FIFO_DEPTH;
      for (int n = 0; n < 2; n++) begin
         ok[n] = (inf == 0) || (opv[n][1] == m_mode);
         el[n] = v[n] && ok[n] && credit;
         eg[n] = 1'b0;
      end
      p = m_rr ? 1 : 0;
      if (!rst) begin
         if (el[p]) eg[p] = 1'b1;
         else if (!(v[p] && credit && !ok[p]) && el[1-p]) eg[1-p] = 1'b1;
      end
      exp_rv   = fc > 0;
      exp_head = (fc > 0) ? fq[0] : '0;
      exp_busy = (inf > 0) || (fc > 0);
   endtask

   // Cross the rising edge and advance the model.
   task automatic advance();
      int gi;
      @(posedge clk);
      if (rst) begin
         pend_t.delete(); pend_e.delete(); fq.delete();
         m_mode = 1'b0; m_rr = 1'b0;
      end else begin
         if (resp_ready && fq.size() > 0) void'(fq.pop_front());
         if (pend_t.size() > 0 && pend_t[0] == cyc - SH_LAT) begin
            void'(pend_t.pop_front());
            fq.push_back(pend_e.pop_front());
         end
         if (eg[0] || eg[1]) begin
            gi = eg[1] ? 1 : 0;
            if (m_inf == 0) m_mode = opv[gi][1];
            pend_t.push_back(cyc);
            pend_e.push_back({gi[0], shf(av[gi], opv[gi], bv[gi])});
            m_rr = (gi == 0);
         end
      end
      cyc++;
      #1;
   endtask

   task automatic quiesce();
      int w = 0;
      r0_valid = 0; r1_valid = 0; resp_ready = 1;
      while ((busy || pend_t.size() > 0 || fq.size() > 0) && w < 100) begin settle(); advance(); w++; end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL quiesce: busy=%b after %0d cycles, want 0", busy, w); end
   endtask

   task automatic test_reset();
      rst = 1;
      set_req(0, 1, 32'h1, 2'b00, 5'd0);
      set_req(1, 1, 32'h2, 2'b00, 5'd0);
      for (int i = 0; i < 3; i++) begin
         settle();
         n_cmp++;
         if ({r0_ready, r1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b%b want 00", r0_ready, r1_ready); end
         advance();
      end
      rst = 0; r0_valid = 0; r1_valid = 0;
      settle();
      n_cmp++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      advance();
   endtask

   task automatic test_basic();
      int k;
      bit g0, g1;
      logic [32:0] got[$];
      logic [32:0] want[2];
      resp_ready = 0;
      set_req(0, 1, 32'h1, 2'b00, 5'd4);
      settle();
      n_cmp++;
      if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL basic_grant: got %b want 1", r0_ready); end
      advance();
      r0_valid = 0;
      k = 1;
      while (k < 20) begin settle(); if (resp_valid) break; advance(); k++; end
      n_cmp++;
      if (k != 8) begin n_fail++; $display("FAIL basic_latency: resp_valid after %0d clocks, want 8", k); end
      n_cmp++;
      if ({resp_id, resp_data} !== 33'h0_0000_0010) begin n_fail++; $display("FAIL basic_sll: got id=%0d data=%h want id=0 data=00000010", resp_id, resp_data); end
      resp_ready = 1;
      advance();
      set_req(1, 1, 32'h1, 2'b11, 5'd1);
      set_req(0, 1, 32'h8000_0000, 2'b01, 5'd31);
      for (int c = 0; c < 40 && got.size() < 2; c++) begin
         settle();
         n_cmp++;
         if ({r0_ready, r1_ready} !== {eg[0], eg[1]}) begin n_fail++; $display("FAIL basic_arb: got %b%b want %b%b", r0_ready, r1_ready, eg[0], eg[1]); end
         if (resp_valid) got.push_back({resp_id, resp_data});
         g0 = r0_ready; g1 = r1_ready;
         advance();
         if (g0) r0_valid = 0;
         if (g1) r1_valid = 0;
      end
      want[0] = 33'h1_8000_0000;
      want[1] = 33'h0_0000_0001;
      n_cmp++;
      if (got.size() != 2) begin n_fail++; $display("FAIL basic_count: got %0d responses want 2", got.size()); end
      else for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (got[i] !== want[i]) begin n_fail++; $display("FAIL basic_rot[%0d]: got %h want %h", i, got[i], want[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int issued = 0, last = -1, eighth = -1, c = 0, gid;
      bit alt_ok = 1;
      resp_ready = 1;
      set_req(0, 1, $urandom, {1'b0, 1'($urandom)}, 5'($urandom));
      set_req(1, 1, $urandom, {1'b0, 1'($urandom)}, 5'($urandom));
      while (issued < 12 && c < 60) begin
         settle();
         n_cmp++;
         if ({r0_ready, r1_ready} !== {eg[0], eg[1]}) begin n_fail++; $display("FAIL b2b_grant c=%0d: got %b%b want %b%b", c, r0_ready, r1_ready, eg[0], eg[1]); end
         if (exp_rv) begin
            n_cmp++;
            if ({resp_id, resp_data} !== exp_head) begin n_fail++; $display("FAIL b2b_order: got %h want %h", {resp_id, resp_data}, exp_head); end
         end
         gid = -1;
         if (r0_ready || r1_ready) begin
            gid = r1_ready ? 1 : 0;
            if (last >= 0 && gid == last) alt_ok = 0;
            last = gid; issued++;
            if (issued == 8) eighth = c;
         end
         advance();
         if (gid >= 0) set_req(gid, 1, $urandom, {1'b0, 1'($urandom)}, 5'($urandom));
         c++;
      end
      n_cmp++;
      if (!alt_ok) begin n_fail++; $display("FAIL b2b_alternate: grants repeated an id, want strict alternation"); end
      n_cmp++;
      if (eighth != 7) begin n_fail++; $display("FAIL b2b_rate: 8th issue at cycle %0d want 7", eighth); end
      r0_valid = 0; r1_valid = 0;
      for (int d = 0; d < 60 && (pend_t.size() + fq.size()) > 0; d++) begin
         settle();
         if (exp_rv) begin
            n_cmp++;
            if ({resp_id, resp_data} !== exp_head) begin n_fail++; $display("FAIL b2b_drain: got %h want %h", {resp_id, resp_data}, exp_head); end
         end
         advance();
      end
   endtask

   task automatic test_mode_hazard();
      int w = 0;
      logic [32:0] got[$];
      logic [32:0] want[2];
      logic [31:0] a0, a1;
      logic [4:0]  b0, b1;
      a0 = $urandom; a1 = $urandom; b0 = 5'($urandom); b1 = 5'($urandom | 1);
      resp_ready = 1;
      set_req(0, 1, a0, 2'b00, b0);
      settle();
      n_cmp++;
      if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL hz_sll_grant: got %b want 1", r0_ready); end
      advance();
      r0_valid = 0;
      set_req(1, 1, a1, 2'b10, b1);
      while (w < 20) begin
         settle();
         n_cmp++;
         if ({r0_ready, r1_ready} !== {eg[0], eg[1]}) begin n_fail++; $display("FAIL hz_grant w=%0d: got %b%b want %b%b", w, r0_ready, r1_ready, eg[0], eg[1]); end
         if (resp_valid) got.push_back({resp_id, resp_data});
         if (r1_ready) break;
         advance(); w++;
      end
      n_cmp++;
      if (w != 7) begin n_fail++; $display("FAIL hz_hold: ROL held %0d clocks want 7", w); end
      advance();
      r1_valid = 0;
      for (int c = 0; c < 20 && got.size() < 2; c++) begin
         settle();
         if (resp_valid) got.push_back({resp_id, resp_data});
         advance();
      end
      want[0] = {1'b0, shf(a0, 2'b00, b0)};
      want[1] = {1'b1, shf(a1, 2'b10, b1)};
      n_cmp++;
      if (got.size() != 2) begin n_fail++; $display("FAIL hz_count: got %0d responses want 2", got.size()); end
      else for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (got[i] !== want[i]) begin n_fail++; $display("FAIL hz_result[%0d]: got %h want %h", i, got[i], want[i]); end
      end
   endtask

   task automatic test_credit();
      int n = 0, gid;
      resp_ready = 0;
      set_req(0, 1, $urandom, {1'b1, 1'($urandom)}, 5'($urandom));
      set_req(1, 1, $urandom, {1'b1, 1'($urandom)}, 5'($urandom));
      for (int c = 0; c < 40; c++) begin
         settle();
         n_cmp++;
         if ({r0_ready, r1_ready} !== {eg[0], eg[1]}) begin n_fail++; $display("FAIL credit_grant c=%0d: got %b%b want %b%b", c, r0_ready, r1_ready, eg[0], eg[1]); end
         gid = (r0_ready || r1_ready) ? (r1_ready ? 1 : 0) : -1;
         if (gid >= 0) n++;
         advance();
         if (gid >= 0) set_req(gid, 1, $urandom, {1'b1, 1'($urandom)}, 5'($urandom));
      end
      n_cmp++;
      if (n != FIFO_DEPTH) begin n_fail++; $display("FAIL credit_fill: accepted %0d want %0d", n, FIFO_DEPTH); end
      settle();
      n_cmp++;
      if ({r0_ready, r1_ready} !== 2'b00) begin n_fail++; $display("FAIL credit_stall: got %b%b want 00", r0_ready, r1_ready); end
      resp_ready = 1;
      advance();
      resp_ready = 0;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         settle();
         if (r0_ready || r1_ready) n++;
         gid = (r0_ready || r1_ready) ? (r1_ready ? 1 : 0) : -1;
         advance();
         if (gid >= 0) set_req(gid, 1, $urandom, {1'b1, 1'($urandom)}, 5'($urandom));
      end
      n_cmp++;
      if (n != 1) begin n_fail++; $display("FAIL credit_one: accepted %0d after one pop want 1", n); end
      r0_valid = 0; r1_valid = 0; resp_ready = 1;
      for (int d = 0; d < 60 && (pend_t.size() + fq.size()) > 0; d++) begin
         settle();
         if (exp_rv) begin
            n_cmp++;
            if ({resp_id, resp_data} !== exp_head) begin n_fail++; $display("FAIL credit_drain: got %h want %h", {resp_id, resp_data}, exp_head); end
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      resp_ready = 0;
      r1_valid = 0;
      for (int c = 0; c < 9; c++) begin
         set_req(0, (c == 0 || c == 1 || c >= 6), $urandom, 2'b00, 5'($urandom));
         settle();
         n_cmp++;
         if ({r0_ready, r1_ready} !== {eg[0], eg[1]}) begin n_fail++; $display("FAIL rstmid_grant c=%0d: got %b%b want %b%b", c, r0_ready, r1_ready, eg[0], eg[1]); end
         advance();
      end
      r0_valid = 0;
      rst = 1;
      settle();
      n_cmp++;
      if ({resp_valid, busy} !== 2'b11 || pend_t.size() != 3 || fq.size() != 2) begin
         n_fail++; $display("FAIL rstmid_pre: resp_valid=%b busy=%b inflight=%0d queued=%0d want 1 1 3 2", resp_valid, busy, pend_t.size(), fq.size());
      end
      advance();
      rst = 0;
      resp_ready = 1;
      for (int c = 0; c < 11; c++) begin
         settle();
         n_cmp++;
         if ({resp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_post c=%0d: resp_valid=%b busy=%b want 0 0", c, resp_valid, busy); end
         advance();
      end
   endtask

   task automatic test_random();
      bit need[2], g[2];
      need[0] = 1; need[1] = 1;
      for (int c = 0; c < 400; c++) begin
         for (int n = 0; n < 2; n++)
            if (need[n]) set_req(n, $urandom_range(0, 3) != 0, $urandom, 2'($urandom), 5'($urandom));
         resp_ready = ($urandom_range(0, 3) != 0);
         settle();
         n_cmp++;
         if ({r0_ready, r1_ready} !== {eg[0], eg[1]}) begin n_fail++; $display("FAIL rnd_grant c=%0d: got %b%b want %b%b", c, r0_ready, r1_ready, eg[0], eg[1]); end
         n_cmp++;
         if ({resp_valid, busy} !== {exp_rv, exp_busy}) begin n_fail++; $display("FAIL rnd_status c=%0d: valid/busy %b%b want %b%b", c, resp_valid, busy, exp_rv, exp_busy); end
         if (exp_rv) begin
            n_cmp++;
            if ({resp_id, resp_data} !== exp_head) begin n_fail++; $display("FAIL rnd_resp c=%0d: got %h want %h", c, {resp_id, resp_data}, exp_head); end
         end
         g[0] = r0_ready; g[1] = r1_ready;
         advance();
         need[0] = !v[0] || g[0];
         need[1] = !v[1] || g[1];
      end
      r0_valid = 0; r1_valid = 0; resp_ready = 1;
      for (int d = 0; d < 60 && (pend_t.size() + fq.size()) > 0; d++) begin
         settle();
         if (exp_rv) begin
            n_cmp++;
            if ({resp_id, resp_data} !== exp_head) begin n_fail++; $display("FAIL rnd_drain: got %h want %h", {resp_id, resp_data}, exp_head); end
         end
         advance();
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; cyc = 0;
      m_mode = 0; m_rr = 0; m_inf = 0;
      rst = 1; resp_ready = 0;
      set_req(0, 0, '0, 2'b00, 5'd0);
      set_req(1, 0, '0, 2'b00, 5'd0);
      test_reset();
      quiesce();
      test_basic();
      quiesce();
      test_back_to_back();
      quiesce();
      test_mode_hazard();
      quiesce();
      test_credit();
      quiesce();
      test_reset_mid();
      quiesce();
      test_random();
      quiesce();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
